ex_divider: RTL and testbench

- Multi-cycle 32-bit integer divider in the execute stage of the dual-issue pipeline.
- Directly consumes the forwarded operands produced by the execute-stage operand forwarding unit: `op_a` is the forwarded rs and `op_b` is the forwarded rt.
- Produces quotient (LO) and remainder (HI) for DIV/DIVU.
- Raises a stall request that freezes the pipeline while iterating.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/ex_divider.sv | 135 +++++++++++++
 tb/tb_ex_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divider: FSM state encoding,
// datapath width, iteration count and iteration-counter width.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// {rem,quo} is shifted left by one; the divisor is trial-subtracted from the
// widened remainder and the quotient bit records whether it fit.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_DATA_W
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       trial_neg;

  // Because rem < divisor holds between steps, bit W of the 33-bit
  // difference is a reliable borrow flag.
  always_comb begin
    shifted   = {rem, quo[W-1]};
    trial     = shifted - {1'b0, divisor};
    trial_neg = trial[W];
    rem_next  = trial_neg ? shifted[W-1:0] : trial[W-1:0];
    quo_next  = {quo[W-2:0], ~trial_neg};
  end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle 32-bit DIV/DIVU unit in the execute stage.
// Works on magnitudes with a restoring loop (one bit per cycle), then applies
// the quotient/remainder signs in a dedicated fix-up cycle before presenting
// results in DONE. Requests a pipeline stall while a division is in flight.
// Optional build macro: DIV_EARLY_EXIT_EN -- finishes in DONE straight from
// IDLE when |dividend| < |divisor| (non-zero divisor).
module ex_divider
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int ITER   = DIV_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_t state_reg, state_next;

  logic [DIV_CNT_W-1:0] cnt_reg;
  logic                 last_reg;
  logic                 sign_q_reg;
  logic                 sign_r_reg;
  logic [DATA_W-1:0]    rem_reg;
  logic [DATA_W-1:0]    quo_reg;
  logic [DATA_W-1:0]    divisor_reg;
  logic [DATA_W-1:0]    quotient_reg;
  logic [DATA_W-1:0]    remainder_reg;

  logic [DATA_W-1:0]    step_rem;
  logic [DATA_W-1:0]    step_quo;
  logic [DATA_W-1:0]    a_mag;
  logic [DATA_W-1:0]    b_mag;
  logic                 b_zero;
  logic                 launch;
  logic                 early;

  div_step #(.W(DATA_W)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes and launch qualification; 0x80000000 maps to itself.
  always_comb begin
    a_mag  = (is_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    b_mag  = (is_signed && op_b[DATA_W-1]) ? -op_b : op_b;
    b_zero = (op_b == '0);
    launch = (state_reg == IDLE) && start && !flush;
`ifdef DIV_EARLY_EXIT_EN
    early  = launch && (a_mag < b_mag) && !b_zero;
`else
    early  = 1'b0;
`endif
  end

  // Next-state selection; flush cancels from any state.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = early ? DONE : CALC;
        CALC:    if (last_reg) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_reg      <= 1'b0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        // A zero divisor yields all-ones regardless of signedness, so the
        // quotient is never negated in that case.
        sign_q_reg  <= is_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]) && !b_zero;
        sign_r_reg  <= is_signed && op_a[DATA_W-1];
        quo_reg     <= a_mag;
        divisor_reg <= b_mag;
        rem_reg     <= '0;
        cnt_reg     <= '0;
        last_reg    <= 1'b0;
        if (early) begin
          quotient_reg  <= '0;
          remainder_reg <= op_a;
        end
      end else if (state_reg == CALC && !flush) begin
        if (!last_reg) begin
          rem_reg  <= step_rem;
          quo_reg  <= step_quo;
          cnt_reg  <= cnt_reg + 1'b1;
          last_reg <= (cnt_reg == DIV_CNT_W'(ITER - 1));
        end else begin
          // Sign fix-up gets its own cycle so the negators are not chained
          // behind the trial subtractor.
          quotient_reg  <= sign_q_reg ? -quo_reg : quo_reg;
          remainder_reg <= sign_r_reg ? -rem_reg : rem_reg;
          last_reg      <= 1'b0;
        end
      end
    end
  end

  assign stall_req = launch || (state_reg == CALC);
  assign busy      = (state_reg == CALC);
  assign done      = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_ex_divider.sv
// Directed-vector bench for ex_divider: latency, stall window, signed and
// unsigned results, divide-by-zero, overflow, flush, reset and start-ignore.
// Honours DIV_EARLY_EXIT_EN when computing expected latencies.
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = FULL_LAT;
`endif

  ex_divider dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one division at a negedge, watch the stall window, and check the
  // done cycle. With hold=1, start stays high (with junk operands) until done.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int exp_lat, input logic hold);
    int n;
    int stall_err;
    start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
    #1;
    check_val({tag, "_stall_start"}, 32'(stall_req), 32'd1);
    n = 0;
    stall_err = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      else begin op_a = 32'd99; op_b = 32'd1; is_signed = 1'b0; end
      if (done) begin n = i; break; end
      if (!stall_req) stall_err++;
    end
    if (n == 0) n = 101;
    start = 1'b0;
    #1;
    check_val({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check_val({tag, "_quotient"}, quotient, exp_q);
    check_val({tag, "_remainder"}, remainder, exp_r);
    check_val({tag, "_stall_window"}, 32'(stall_err), 32'd0);
    check_val({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    $display("div %s signed=%0d a=%h b=%h q=%h r=%h lat=%0d", tag, sgn, a, b, quotient, remainder, n);
    @(negedge clk);
    check_val({tag, "_pulse_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_stall", 32'(stall_req), 32'd0);
    check_val("rst_quotient", quotient, 32'd0);
    check_val("rst_remainder", remainder, 32'd0);
    $display("reset released busy=%0d done=%0d q=%h r=%h", busy, done, quotient, remainder);
    @(negedge clk);

    run_div("divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         FULL_LAT, 1'b0);
    run_div("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, FULL_LAT, 1'b0);
    run_div("divu_m7_2",    1'b0, 32'hFFFFFFF9, 32'd2,         32'h7FFFFFFC, 32'd1,         FULL_LAT, 1'b0);
    run_div("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,         FULL_LAT, 1'b0);
    run_div("divu_5_0",     1'b0, 32'd5,         32'd0,         32'hFFFFFFFF, 32'd5,         FULL_LAT, 1'b0);
    run_div("div_m8_0",     1'b1, 32'hFFFFFFF8, 32'd0,         32'hFFFFFFFF, 32'hFFFFFFF8, FULL_LAT, 1'b0);
    run_div("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,         FULL_LAT, 1'b0);
    run_div("divu_3_10",    1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         EE_LAT,   1'b0);
    run_div("div_m3_10",    1'b1, 32'hFFFFFFFD, 32'd10,        32'd0,         32'hFFFFFFFD, EE_LAT,   1'b0);
    run_div("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,         32'hFFFFFFFF, 32'd0,         FULL_LAT, 1'b0);

    // flush wins over start while idle
    start = 1'b1; flush = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    #1;
    check_val("flush_prio_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check_val("flush_prio_busy", 32'(busy), 32'd0);
    $display("flush+start idle busy=%0d", busy);
    @(negedge clk);

    // flush in cycle 10 of a running division
    start = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    if (done) seen++;
    check_val("flush_busy", 32'(busy), 32'd0);
    check_val("flush_no_done", 32'(seen), 32'd0);
    check_val("flush_keep_q", quotient, 32'hFFFFFFFF);
    check_val("flush_keep_r", remainder, 32'd0);
    $display("flush mid-calc busy=%0d q=%h r=%h", busy, quotient, remainder);
    @(negedge clk);
    run_div("after_flush", 1'b0, 32'd50, 32'd7, 32'd7, 32'd1, FULL_LAT, 1'b0);

    // synchronous reset mid-calculation
    start = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    check_val("midrst_q", quotient, 32'd0);
    check_val("midrst_r", remainder, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val("midrst_no_done", 32'(seen), 32'd0);
    $display("reset mid-calc q=%h r=%h done_seen=%0d", quotient, remainder, seen);

    // start held high through CALC/DONE is ignored
    run_div("hold_start", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, FULL_LAT, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val("hold_single_done", 32'(seen), 32'd0);
    check_val("idle_stall", 32'(stall_req), 32'd0);
    $display("start-hold extra done pulses=%0d", seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
